// File: rtl/fft_icore2_pkg.sv
// Shared widths and twiddle type for the inverse butterfly core (fft_icore2).
`include "fft_defines.vh"

package fft_icore2_pkg;

  localparam int unsigned WnWd  = `CFG_WN_WD;
  localparam int unsigned FraWd = `DATA_FRA_WD;

`ifdef FFT_ICORE_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  typedef struct packed {
    logic signed [WnWd-1:0] wr;
    logic signed [WnWd-1:0] wi;
  } twiddle_t;

endpackage

// File: rtl/fft_defines.vh
// Shared FFT datapath widths. Uncomment FFT_ICORE_ROUND_EN to switch the
// inverse butterfly from floor to round-half-up scaling.
`ifndef FFT_DEFINES_VH
`define FFT_DEFINES_VH

`define CFG_WN_WD   10
`define DATA_FRA_WD 8
// `define FFT_ICORE_ROUND_EN

`endif

// File: rtl/fft_wn_rom.sv
// Conjugate twiddle table for a 64-point transform with 8 fraction bits:
// wr = round(cos(2*pi*k/64)*256), wi = +round(sin(2*pi*k/64)*256).
module fft_wn_rom
  import fft_icore2_pkg::*;
(
  input  logic [4:0] k_i,
  output twiddle_t   wn_o
);

  // Quarter-wave cosine table; sine is read mirrored as cos(16 - j).
  function automatic int cos_q(input int j);
    case (j)
      0:       return 256;
      1:       return 255;
      2:       return 251;
      3:       return 245;
      4:       return 237;
      5:       return 226;
      6:       return 213;
      7:       return 198;
      8:       return 181;
      9:       return 162;
      10:      return 142;
      11:      return 121;
      12:      return 98;
      13:      return 74;
      14:      return 50;
      15:      return 25;
      default: return 0;
    endcase
  endfunction

  always_comb begin
    if (k_i < 5'd16) begin
      wn_o.wr = WnWd'(cos_q(int'(k_i)));
      wn_o.wi = WnWd'(cos_q(16 - int'(k_i)));
    end else begin
      wn_o.wr = WnWd'(-cos_q(32 - int'(k_i)));
      wn_o.wi = WnWd'(cos_q(int'(k_i) - 16));
    end
  end

endmodule

// File: rtl/fft_icore2.sv
// Three-stage inverse radix-2 butterfly: a = (X+Y)/2, b = (X-Y)*conj(W)/2.
// Define FFT_ICORE_ROUND_EN for round-half-up instead of floor on the S3 shifts.
module fft_icore2
  import fft_icore2_pkg::*;
#(
  parameter int unsigned DATA_INP_WD = 16,
  parameter int unsigned DATA_OUT_WD = 16,
  parameter int unsigned FFT_N       = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fft_vld_i,
  output logic                       fft_rdy_o,
  input  logic [2*DATA_INP_WD-1:0]   fft_dat1_i,
  input  logic [2*DATA_INP_WD-1:0]   fft_dat2_i,
  input  logic [$clog2(FFT_N)-2:0]   fft_idx_i,
  output logic                       fft_vld_o,
  input  logic                       fft_rdy_i,
  output logic [2*DATA_OUT_WD-1:0]   fft_dat1_o,
  output logic [2*DATA_OUT_WD-1:0]   fft_dat2_o
);

  localparam int unsigned SW = DATA_INP_WD + 1;
  localparam int unsigned MW = SW + WnWd;
  localparam int unsigned PW = MW + 1;

  if (WnWd < FraWd + 2) begin : g_wn_chk
    $error("CFG_WN_WD cannot represent a +1.0 twiddle");
  end
  if (FFT_N != 64 || FraWd != 8) begin : g_rom_chk
    $error("fft_wn_rom table is built for FFT_N=64, DATA_FRA_WD=8");
  end

`ifdef FFT_ICORE_ROUND_EN
  localparam logic signed [PW-1:0] RndA = PW'(1);
  localparam logic signed [PW-1:0] RndB = PW'(1) <<< FraWd;
`else
  localparam logic signed [PW-1:0] RndA = '0;
  localparam logic signed [PW-1:0] RndB = '0;
`endif

  function automatic logic signed [DATA_OUT_WD-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] hi, lo;
    hi = {{(PW-DATA_OUT_WD+1){1'b0}}, {(DATA_OUT_WD-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      return hi[DATA_OUT_WD-1:0];
    else if (v < lo) return lo[DATA_OUT_WD-1:0];
    else             return v[DATA_OUT_WD-1:0];
  endfunction

  logic en;
  logic signed [DATA_INP_WD-1:0] x_re, x_im, y_re, y_im;
  twiddle_t rom_wn;

  logic signed [SW-1:0]   s_re_d, s_re_q, s_im_d, s_im_q, d_re_d, d_re_q, d_im_d, d_im_q;
  logic signed [WnWd-1:0] wr_q, wi_q;
  logic                   v1_q, v2_q, vld_o_q;
  logic signed [MW-1:0]   m_rr_d, m_rr_q, m_ii_d, m_ii_q, m_ri_d, m_ri_q, m_ir_d, m_ir_q;
  logic signed [SW-1:0]   s2_re_q, s2_im_q;
  logic signed [PW-1:0]   p_re, p_im, a_re_w, a_im_w, b_re_w, b_im_w;
  logic [2*DATA_OUT_WD-1:0] dat1_d, dat1_q, dat2_d, dat2_q;

  assign x_re = fft_dat1_i[2*DATA_INP_WD-1 -: DATA_INP_WD];
  assign x_im = fft_dat1_i[DATA_INP_WD-1:0];
  assign y_re = fft_dat2_i[2*DATA_INP_WD-1 -: DATA_INP_WD];
  assign y_im = fft_dat2_i[DATA_INP_WD-1:0];

  // A single enable stalls every stage together, so bubbles stay in place.
  assign en        = ~vld_o_q | fft_rdy_i;
  assign fft_rdy_o = en;

  fft_wn_rom u_wn_rom (
    .k_i  (fft_idx_i),
    .wn_o (rom_wn)
  );

  always_comb begin
    s_re_d = SW'(x_re) + SW'(y_re);
    s_im_d = SW'(x_im) + SW'(y_im);
    d_re_d = SW'(x_re) - SW'(y_re);
    d_im_d = SW'(x_im) - SW'(y_im);

    m_rr_d = MW'(d_re_q) * MW'(wr_q);
    m_ii_d = MW'(d_im_q) * MW'(wi_q);
    m_ri_d = MW'(d_re_q) * MW'(wi_q);
    m_ir_d = MW'(d_im_q) * MW'(wr_q);

    p_re   = PW'(m_rr_q) - PW'(m_ii_q);
    p_im   = PW'(m_ri_q) + PW'(m_ir_q);
    a_re_w = (PW'(s2_re_q) + RndA) >>> 1;
    a_im_w = (PW'(s2_im_q) + RndA) >>> 1;
    b_re_w = (p_re + RndB) >>> (FraWd + 1);
    b_im_w = (p_im + RndB) >>> (FraWd + 1);
    dat1_d = {sat(a_re_w), sat(a_im_w)};
    dat2_d = {sat(b_re_w), sat(b_im_w)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_re_q  <= '0;
      s_im_q  <= '0;
      d_re_q  <= '0;
      d_im_q  <= '0;
      wr_q    <= '0;
      wi_q    <= '0;
      v1_q    <= 1'b0;
      m_rr_q  <= '0;
      m_ii_q  <= '0;
      m_ri_q  <= '0;
      m_ir_q  <= '0;
      s2_re_q <= '0;
      s2_im_q <= '0;
      v2_q    <= 1'b0;
      dat1_q  <= '0;
      dat2_q  <= '0;
      vld_o_q <= 1'b0;
    end else if (en) begin
      s_re_q  <= s_re_d;
      s_im_q  <= s_im_d;
      d_re_q  <= d_re_d;
      d_im_q  <= d_im_d;
      wr_q    <= rom_wn.wr;
      wi_q    <= rom_wn.wi;
      v1_q    <= fft_vld_i;
      m_rr_q  <= m_rr_d;
      m_ii_q  <= m_ii_d;
      m_ri_q  <= m_ri_d;
      m_ir_q  <= m_ir_d;
      s2_re_q <= s_re_q;
      s2_im_q <= s_im_q;
      v2_q    <= v1_q;
      dat1_q  <= dat1_d;
      dat2_q  <= dat2_d;
      vld_o_q <= v2_q;
    end
  end

  assign fft_vld_o  = vld_o_q;
  assign fft_dat1_o = dat1_q;
  assign fft_dat2_o = dat2_q;

endmodule
